wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
MEM/WB pipeline register plus write-back logic for the 5-stage MIPS pipeline.
- Captures memory-stage results each cycle.
- Extends load data by byte/half/word type.
- Selects the write-back value.
- Drives the register file's write port (WE, A3, WD) and the write-back PC used for its trace line.
- Sits directly downstream of the data memory and directly upstream of the register file.

Parameters:
- PC_W, 32, width of PC fields.
- DATA_W, 32, data width; only 32 is supported.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- stall  in  1  hold the WB register contents.
- flush  in  1  load a bubble into WB.
- m_valid  in  1  the MEM-stage instruction is real.
- m_reg_we  in  1  the MEM-stage instruction writes a GPR.
- m_a3  in  5  destination register.
- m_wd_sel  in  3  write-back source select.
- m_load_type  in  3  load extension type.
- m_alu_res  in  32  ALU result; [1:0] is also the load byte offset.
- m_dm_rdata  in  32  raw data-memory word.
- m_hilo  in  32  HI/LO read value (mfhi/mflo).
- m_pc  in  32  PC of the MEM-stage instruction.
- grf_we  out  1  register-file write enable.
- grf_a3  out  5  register-file write address.
- grf_wd  out  32  register-file write data.
- grf_pca  out  32  PC of the instruction being written back.
- w_valid  out  1  WB stage holds a real instruction.

Behaviour:
Register update priority each posedge:
- reset: clear all WB registers; w_valid=0, grf_we=0, grf_a3=0, grf_wd=0, grf_pca=0.
- else flush: bubble; valid=0 and reg_we=0, other fields don't-care but cleared to 0.
- else stall: hold every field.
- else: capture all m_* inputs.
- Reset mid-stall or mid-flush: reset wins.
- Simultaneous flush and stall: flush wins.

Latency and output timing:
- One cycle. A MEM-stage value at edge N appears on the grf_* outputs after edge N.
- The register file writes it at edge N+1.
- Outputs are combinational from the WB registers only; no input-to-output path.

grf_we:
- grf_we = valid & reg_we & (a3 != 0).
- A write to $0 is suppressed here, so grf_we is never 1 with grf_a3=0.

Write-back select (wd_sel):
- 0: ALU result.
- 1: extended load data.
- 2: pc+8 (jal/jalr link), 32-bit wrap-around.
- 3: hilo.
- 4..7: 0.

Load extension (load_type, offset = alu_res[1:0]):
- 0 lw: the whole word.
- 1 lb: sign-extended byte. Byte 0 = rdata[7:0] ... byte 3 = rdata[31:24].
- 2 lbu: zero-extended byte.
- 3 lh: sign-extended half selected by offset[1]; offset[0] ignored.
- 4 lhu: zero-extended half selected the same way.
- 5..7: treated as lw.

Stall and data:
- Stall never re-triggers a write; it holds the same WE/A3/WD.
- The upstream hazard unit guarantees no duplicate commit. Stall is only asserted together with an upstream-inserted bubble or a held WB.
- This block adds no masking of its own.

Optional Feature:
- WB_FWD_EN
- Defined: adds outputs fwd_we (1), fwd_a3 (5) and fwd_wd (32), equal to grf_we, grf_a3 and grf_wd, for the hazard/forwarding unit. This gives WB->EX/ID forwarding.
- Undefined: those ports do not exist. The register file is the only consumer, and forwarding comes from other stages.

Decomposition:
- Shared package mips_defs holds:
  - WD_SEL_ALU/MEM/PC8/HILO constants, 3-bit.
  - LD_LW/LB/LBU/LH/LHU constants, 3-bit.
  - REG_ZERO = 5'd0.
- Sub-module load_ext: pure combinational (rdata, offset, load_type) -> extended data. It is reused by the verification model.

Test Plan:
- Reset with m_reg_we=1, m_a3=8 -> every output 0 for the cycle after reset; the first capture follows the first non-reset edge.
- Load byte: m_dm_rdata=0x80FF7F01, lb, offset 3, a3=9, wd_sel=1 -> grf_wd=0xFFFFFF80, grf_we=1.
  - Same word, lbu offset 2 -> 0x000000FF.
  - Same word, lh offset 2 -> 0xFFFF80FF.
- Link write: wd_sel=2, m_pc=0x00003010, a3=31 -> grf_wd=0x00003018, grf_pca=0x00003010.
  - m_pc=0xFFFFFFFC -> grf_wd=0x00000004.
- $0 suppression: m_reg_we=1, a3=0, alu=0x1234 -> grf_we=0.
  - wd_sel=5 with a3=4 -> grf_we=1, grf_wd=0.
- Stall hold then flush: capture a3=5, alu=0xAA; stall for 3 cycles -> outputs unchanged.
  - Then flush and stall together -> w_valid=0, grf_we=0 on the next cycle.
- Flush vs reset: assert flush and reset in the same cycle with a pending write -> all outputs 0.
  - Release both -> the next capture is normal.

Source files
------------

// File: rtl/mips_defs.sv
`default_nettype none
// ============================================================================
//  Module      : mips_defs (package)
//  Description : Shared encodings for the MIPS pipeline write-back path:
//                write-back source selects, load extension types and the
//                hard-wired zero register index.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_defs;

    // Write-back source select (3-bit; codes 4..7 select zero)
    localparam logic [2:0] WD_SEL_ALU  = 3'd0;
    localparam logic [2:0] WD_SEL_MEM  = 3'd1;
    localparam logic [2:0] WD_SEL_PC8  = 3'd2;
    localparam logic [2:0] WD_SEL_HILO = 3'd3;

    // Load extension type (3-bit; codes 5..7 behave as lw)
    localparam logic [2:0] LD_LW  = 3'd0;
    localparam logic [2:0] LD_LB  = 3'd1;
    localparam logic [2:0] LD_LBU = 3'd2;
    localparam logic [2:0] LD_LH  = 3'd3;
    localparam logic [2:0] LD_LHU = 3'd4;

    // $0 is hard-wired to zero and must never be written
    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage : mips_defs
`default_nettype wire

// File: rtl/load_ext.sv
`default_nettype none
// ============================================================================
//  Module      : load_ext
//  Description : Combinational load-data extender. Picks the addressed byte
//                or half-word out of the raw memory word and sign/zero
//                extends it according to the load type.
//  Revision    : 1.0 - initial release
// ============================================================================
module load_ext
    import mips_defs::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  load_type,
    output logic [31:0] ext_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Select the addressed byte (little-endian lanes) and half-word
    always_comb begin
        w_byte = rdata[7:0];
        case (offset)
            2'd0: w_byte = rdata[7:0];
            2'd1: w_byte = rdata[15:8];
            2'd2: w_byte = rdata[23:16];
            2'd3: w_byte = rdata[31:24];
            default: w_byte = rdata[7:0];
        endcase
        // offset[0] is ignored for half-word loads
        w_half = offset[1] ? rdata[31:16] : rdata[15:0];
    end

    // Extend the selected lane; unknown load types return the whole word
    always_comb begin
        ext_data = rdata;
        case (load_type)
            LD_LB:   ext_data = {{24{w_byte[7]}}, w_byte};
            LD_LBU:  ext_data = {24'd0, w_byte};
            LD_LH:   ext_data = {{16{w_half[15]}}, w_half};
            LD_LHU:  ext_data = {16'd0, w_half};
            default: ext_data = rdata;
        endcase
    end

endmodule : load_ext
`default_nettype wire

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : wb_stage
//  Description : MEM/WB pipeline register plus write-back logic. Captures
//                the memory-stage result, extends load data, selects the
//                write-back value and drives the register-file write port.
//                Optional macro WB_FWD_EN adds fwd_we/fwd_a3/fwd_wd outputs
//                mirroring the write port for the forwarding unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_stage
    import mips_defs::*;
#(
    parameter int PC_W   = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              m_valid,
    input  logic              m_reg_we,
    input  logic [4:0]        m_a3,
    input  logic [2:0]        m_wd_sel,
    input  logic [2:0]        m_load_type,
    input  logic [DATA_W-1:0] m_alu_res,
    input  logic [DATA_W-1:0] m_dm_rdata,
    input  logic [DATA_W-1:0] m_hilo,
    input  logic [PC_W-1:0]   m_pc,
    output logic              grf_we,
    output logic [4:0]        grf_a3,
    output logic [DATA_W-1:0] grf_wd,
    output logic [PC_W-1:0]   grf_pca,
`ifdef WB_FWD_EN
    output logic              fwd_we,
    output logic [4:0]        fwd_a3,
    output logic [DATA_W-1:0] fwd_wd,
`endif
    output logic              w_valid
);

    logic              valid_q,     valid_d;
    logic              reg_we_q,    reg_we_d;
    logic [4:0]        a3_q,        a3_d;
    logic [2:0]        wd_sel_q,    wd_sel_d;
    logic [2:0]        load_type_q, load_type_d;
    logic [DATA_W-1:0] alu_res_q,   alu_res_d;
    logic [DATA_W-1:0] dm_rdata_q,  dm_rdata_d;
    logic [DATA_W-1:0] hilo_q,      hilo_d;
    logic [PC_W-1:0]   pc_q,        pc_d;

    logic [DATA_W-1:0] w_ld_data;
    logic [PC_W-1:0]   w_pc8;
    logic [DATA_W-1:0] w_wd;

    // Next-state: flush beats stall, stall holds, otherwise capture MEM
    always_comb begin
        valid_d     = m_valid;
        reg_we_d    = m_reg_we;
        a3_d        = m_a3;
        wd_sel_d    = m_wd_sel;
        load_type_d = m_load_type;
        alu_res_d   = m_alu_res;
        dm_rdata_d  = m_dm_rdata;
        hilo_d      = m_hilo;
        pc_d        = m_pc;
        if (flush) begin
            valid_d     = 1'b0;
            reg_we_d    = 1'b0;
            a3_d        = REG_ZERO;
            wd_sel_d    = 3'd0;
            load_type_d = 3'd0;
            alu_res_d   = '0;
            dm_rdata_d  = '0;
            hilo_d      = '0;
            pc_d        = '0;
        end else if (stall) begin
            valid_d     = valid_q;
            reg_we_d    = reg_we_q;
            a3_d        = a3_q;
            wd_sel_d    = wd_sel_q;
            load_type_d = load_type_q;
            alu_res_d   = alu_res_q;
            dm_rdata_d  = dm_rdata_q;
            hilo_d      = hilo_q;
            pc_d        = pc_q;
        end
    end

    // WB pipeline register; synchronous reset wins over everything
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q     <= 1'b0;
            reg_we_q    <= 1'b0;
            a3_q        <= REG_ZERO;
            wd_sel_q    <= 3'd0;
            load_type_q <= 3'd0;
            alu_res_q   <= '0;
            dm_rdata_q  <= '0;
            hilo_q      <= '0;
            pc_q        <= '0;
        end else begin
            valid_q     <= valid_d;
            reg_we_q    <= reg_we_d;
            a3_q        <= a3_d;
            wd_sel_q    <= wd_sel_d;
            load_type_q <= load_type_d;
            alu_res_q   <= alu_res_d;
            dm_rdata_q  <= dm_rdata_d;
            hilo_q      <= hilo_d;
            pc_q        <= pc_d;
        end
    end

    load_ext u_load_ext (
        .rdata     (dm_rdata_q),
        .offset    (alu_res_q[1:0]),
        .load_type (load_type_q),
        .ext_data  (w_ld_data)
    );

    assign w_pc8 = pc_q + PC_W'(8);

    // Write-back source mux, driven from registered state only
    always_comb begin
        w_wd = '0;
        case (wd_sel_q)
            WD_SEL_ALU:  w_wd = alu_res_q;
            WD_SEL_MEM:  w_wd = w_ld_data;
            WD_SEL_PC8:  w_wd = DATA_W'(w_pc8);
            WD_SEL_HILO: w_wd = hilo_q;
            default:     w_wd = '0;
        endcase
    end

    // Writes to $0 are dropped here so the register file never sees them
    assign grf_we  = valid_q & reg_we_q & (a3_q != REG_ZERO);
    assign grf_a3  = a3_q;
    assign grf_wd  = w_wd;
    assign grf_pca = pc_q;
    assign w_valid = valid_q;

`ifdef WB_FWD_EN
    assign fwd_we = grf_we;
    assign fwd_a3 = grf_a3;
    assign fwd_wd = grf_wd;
`endif

endmodule : wb_stage
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_stage
//  Description : Scoreboard bench for wb_stage. The driver applies directed
//                and random MEM-stage traffic, advances an abstract model of
//                the WB register and queues the expected outputs; a monitor
//                compares them on the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        reset, stall, flush;
    logic        m_valid, m_reg_we;
    logic [4:0]  m_a3;
    logic [2:0]  m_wd_sel, m_load_type;
    logic [31:0] m_alu_res, m_dm_rdata, m_hilo, m_pc;
    logic        grf_we, w_valid;
    logic [4:0]  grf_a3;
    logic [31:0] grf_wd, grf_pca;
`ifdef WB_FWD_EN
    logic        fwd_we;
    logic [4:0]  fwd_a3;
    logic [31:0] fwd_wd;
`endif

    always #5 clk = ~clk;

    wb_stage #(.PC_W(32), .DATA_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .flush       (flush),
        .m_valid     (m_valid),
        .m_reg_we    (m_reg_we),
        .m_a3        (m_a3),
        .m_wd_sel    (m_wd_sel),
        .m_load_type (m_load_type),
        .m_alu_res   (m_alu_res),
        .m_dm_rdata  (m_dm_rdata),
        .m_hilo      (m_hilo),
        .m_pc        (m_pc),
        .grf_we      (grf_we),
        .grf_a3      (grf_a3),
        .grf_wd      (grf_wd),
        .grf_pca     (grf_pca),
`ifdef WB_FWD_EN
        .fwd_we      (fwd_we),
        .fwd_a3      (fwd_a3),
        .fwd_wd      (fwd_wd),
`endif
        .w_valid     (w_valid)
    );

    typedef struct {
        logic        we;
        logic [4:0]  a3;
        logic [31:0] wd;
        logic [31:0] pca;
        logic        valid;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Abstract model of the instruction currently held in WB
    logic        s_valid = 1'b0, s_we = 1'b0;
    logic [4:0]  s_a3 = 5'd0;
    logic [2:0]  s_sel = 3'd0, s_lt = 3'd0;
    logic [31:0] s_alu = 0, s_rd = 0, s_hilo = 0, s_pc = 0;

    // Load value from the architectural rules, using shifts and masks
    function automatic logic [31:0] ref_load(logic [31:0] rd, int off, int lt);
        logic [31:0] b, h;
        b = (rd >> (8 * off)) & 32'h0000_00FF;
        h = (rd >> (16 * (off / 2))) & 32'h0000_FFFF;
        case (lt)
            1: return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
            2: return b;
            3: return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
            4: return h;
            default: return rd;
        endcase
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.valid = s_valid;
        e.we    = s_valid && s_we && (s_a3 != 5'd0);
        e.a3    = s_a3;
        e.pca   = s_pc;
        case (s_sel)
            3'd0: e.wd = s_alu;
            3'd1: e.wd = ref_load(s_rd, int'(s_alu % 4), int'(s_lt));
            3'd2: e.wd = s_pc + 32'd8;
            3'd3: e.wd = s_hilo;
            default: e.wd = 32'd0;
        endcase
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of stimulus, then advance the model and queue its view
    task automatic step(input logic r, input logic f, input logic s,
                        input logic v, input logic we, input logic [4:0] a3,
                        input logic [2:0] sel, input logic [2:0] lt,
                        input logic [31:0] alu, input logic [31:0] rd,
                        input logic [31:0] hilo, input logic [31:0] pc);
        reset = r; flush = f; stall = s;
        m_valid = v; m_reg_we = we; m_a3 = a3; m_wd_sel = sel;
        m_load_type = lt; m_alu_res = alu; m_dm_rdata = rd; m_hilo = hilo; m_pc = pc;
        @(posedge clk);
        if (r || f) begin
            s_valid = 0; s_we = 0; s_a3 = 0; s_sel = 0; s_lt = 0;
            s_alu = 0; s_rd = 0; s_hilo = 0; s_pc = 0;
        end else if (!s) begin
            s_valid = v; s_we = we; s_a3 = a3; s_sel = sel; s_lt = lt;
            s_alu = alu; s_rd = rd; s_hilo = hilo; s_pc = pc;
        end
        exp_q.push_back(model_out());
        #1;
    endtask

    // Monitor: outputs are valid every cycle, compare each queued expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("w_valid", {31'd0, w_valid}, {31'd0, e.valid});
                chk("grf_we",  {31'd0, grf_we},  {31'd0, e.we});
                chk("grf_a3",  {27'd0, grf_a3},  {27'd0, e.a3});
                chk("grf_wd",  grf_wd,  e.wd);
                chk("grf_pca", grf_pca, e.pca);
`ifdef WB_FWD_EN
                chk("fwd_we", {31'd0, fwd_we}, {31'd0, e.we});
                chk("fwd_a3", {27'd0, fwd_a3}, {27'd0, e.a3});
                chk("fwd_wd", fwd_wd, e.wd);
`endif
            end
        end
    end

    initial begin
        logic [31:0] w;
        w = 32'h80FF_7F01;
        // Reset with a pending write: outputs must be all zero
        step(1, 0, 0, 1, 1, 5'd8, 3'd0, 3'd0, 32'h55, 0, 0, 32'h100);
        step(1, 0, 0, 1, 1, 5'd8, 3'd0, 3'd0, 32'h55, 0, 0, 32'h100);
        step(0, 0, 0, 1, 1, 5'd8, 3'd0, 3'd0, 32'h55, 0, 0, 32'h100);
        // Byte / half loads out of the same word
        step(0, 0, 0, 1, 1, 5'd9, 3'd1, 3'd1, 32'h1003, w, 0, 32'h104);
        step(0, 0, 0, 1, 1, 5'd9, 3'd1, 3'd2, 32'h1002, w, 0, 32'h108);
        step(0, 0, 0, 1, 1, 5'd9, 3'd1, 3'd3, 32'h1002, w, 0, 32'h10C);
        step(0, 0, 0, 1, 1, 5'd9, 3'd1, 3'd4, 32'h1001, w, 0, 32'h110);
        // Link writes, including 32-bit wrap of pc+8
        step(0, 0, 0, 1, 1, 5'd31, 3'd2, 3'd0, 0, 0, 0, 32'h0000_3010);
        step(0, 0, 0, 1, 1, 5'd31, 3'd2, 3'd0, 0, 0, 0, 32'hFFFF_FFFC);
        // $0 suppression and reserved select
        step(0, 0, 0, 1, 1, 5'd0, 3'd0, 3'd0, 32'h1234, 0, 0, 32'h200);
        step(0, 0, 0, 1, 1, 5'd4, 3'd5, 3'd0, 32'h1234, 0, 32'h77, 32'h204);
        step(0, 0, 0, 1, 1, 5'd6, 3'd3, 3'd0, 0, 0, 32'hDEAD_BEEF, 32'h208);
        // Capture, stall three cycles with changing inputs, then flush+stall
        step(0, 0, 0, 1, 1, 5'd5, 3'd0, 3'd0, 32'hAA, 0, 0, 32'h300);
        for (int i = 0; i < 3; i++)
            step(0, 0, 1, 1, 1, 5'd7, 3'd0, 3'd0, $urandom, 0, 0, $urandom);
        step(0, 1, 1, 1, 1, 5'd7, 3'd0, 3'd0, 32'h11, 0, 0, 32'h304);
        // Flush and reset together with a pending write, then release
        step(0, 0, 0, 1, 1, 5'd12, 3'd0, 3'd0, 32'h99, 0, 0, 32'h400);
        step(1, 1, 0, 1, 1, 5'd12, 3'd0, 3'd0, 32'h99, 0, 0, 32'h404);
        step(0, 0, 0, 1, 1, 5'd13, 3'd0, 3'd0, 32'h42, 0, 0, 32'h408);
        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom),
                 3'($urandom), 3'($urandom), $urandom, $urandom, $urandom,
                 ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7))
                                             : $urandom);
        end
        reset = 0; flush = 0; stall = 1;
        repeat (3) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_wb_stage
`default_nettype wire
